syscall_unit: RTL
=================

# syscall_unit

Services the MIPS `syscall` instruction by consuming the `$v0` and `$a0` values exported by the register file. It stalls the core while the service runs and emits ASCII bytes on a valid/ready byte stream toward the console or testbench sink. Supported services are print_int, print_char and exit. The block sits beside the register file, and its stall output feeds the core's PC/pipeline enable.

## Interface
Parameters:
- `SVC_PRINT_INT`, default 1: `$v0` code for print signed integer.
- `SVC_EXIT`, default 10: `$v0` code for halt.
- `SVC_PRINT_CHAR`, default 11: `$v0` code for print character.

Ports:
- `clk`  in  1  the single clock. All state changes on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `syscall`  in  1  level. High while a syscall instruction occupies the issuing stage.
- `v0`  in  32  service code, from the register file.
- `a0`  in  32  service argument, from the register file.
- `stall`  out  1  freeze the core's PC and pipeline.
- `out_valid`  out  1  a byte is presented on `out_data`.
- `out_data`  out  8  ASCII byte.
- `out_ready`  in  1  the sink accepts the byte.
- `done`  out  1  one-cycle pulse when a print service completes.
- `halted`  out  1  sticky flag, set by the exit service.
- `unk_code`  out  1  one-cycle pulse for an unsupported code.

## Operation
- States: IDLE, SIGN, SCAN, EMIT, CHAR, DONE, HALT.
- Acceptance happens only in IDLE with `syscall`=1. At acceptance, latch `v0` and `a0`.
  - print_int: go to SIGN.
  - print_char: go to CHAR.
  - exit: go to HALT.
  - any other code: stay in IDLE. Pulse `unk_code` on the next cycle. No stall, no output.
- SIGN: if `a0[31]`=1, present '-' (0x2D), and after the handshake set mag = 0 − a0, taken as unsigned 32-bit. -2147483648 therefore gives mag = 2147483648. If `a0[31]`=0, set mag = a0 with no byte. Then set idx=9, digit=0, started=0 and go to SCAN.
- SCAN, one compare per cycle against pow = POW10[idx]:
  - If mag ≥ pow: mag −= pow, digit++.
  - Otherwise the digit is resolved:
    - If digit≠0, started=1, or idx=0: go to EMIT.
    - Otherwise (leading zero): idx−−, digit=0, stay in SCAN.
- EMIT: present '0'+digit and set started=1. On the handshake:
  - idx=0: go to DONE.
  - otherwise: idx−−, digit=0, go to SCAN.
- CHAR: present `a0[7:0]` unmodified. On the handshake, go to DONE.
- DONE: one cycle with `done`=1 and `stall`=0. `syscall` is ignored in this state. Return to IDLE.
- HALT: terminal. `halted`=1, `stall`=1, no output. Only `rst` leaves this state.
- Output rules:
  - Byte stream handshake: a transfer occurs on a cycle with `out_valid`&`out_ready`.
  - While `out_valid`=1, `out_data` is held stable until the transfer.
  - `out_valid` never depends combinationally on `out_ready`.
- `stall` = (syscall & IDLE & code∈{print_int, print_char, exit}) | state∈{SIGN, SCAN, EMIT, CHAR, HALT}. The IDLE term is combinational so the core freezes in the acceptance cycle.

## Timing
- Reset values, in the cycle after `rst`: state=IDLE, `stall`=0 (apart from the combinational IDLE term), `out_valid`=0, `out_data`=0, `done`=0, `halted`=0, `unk_code`=0.
- `rst` wins over every other event, including in HALT and with a byte pending. A pending byte is dropped and never completed.
- Latency, with `out_ready` held high:
  - print_char: 1 cycle CHAR, then DONE.
  - print_int: at most 10 SCAN cycles per digit position, plus 1 EMIT cycle per digit, plus 1 SIGN cycle, plus DONE. Worst case is about 110 cycles.
- Backpressure stretches SIGN (negative case), EMIT and CHAR only.
- `halted` rises the cycle after exit is accepted.
- `unk_code` pulses the cycle after acceptance.
- `v0` and `a0` are don't-care after acceptance. Only the latched copies are used.

## Structure
- Shared package `syscall_pkg`:
  - state enum.
  - service-code localparams.
  - POW10[0:9] 32-bit constant table (1 … 1_000_000_000).
  - ASCII constants '0' and '-'.
- Natural sub-module: `dec_digit_gen`, covering SCAN/EMIT digit extraction with a mag/idx/digit/started interface and a byte valid/ready handshake. The top-level FSM owns SIGN, CHAR, DONE, HALT and the stall logic.

## Test plan
- print_int, a0=0, `out_ready`=1 → exactly one byte, 0x30. `done` pulses once. `stall` is low in the DONE cycle.
- print_int, a0=0x80000000 → "-2147483648", 11 bytes. No bytes are lost or duplicated.
- print_int, a0=1234, with `out_ready` toggling every other cycle → "1234". `out_data` is stable while stalled by backpressure. `stall` is held high until DONE.
- print_char, a0=0xFFFF_FF41 → a single byte 0x41, then a `done` pulse.
- exit, then `syscall` held and 20 more cycles → `halted`=1 and `stall`=1 throughout, no output. `rst` clears both.
- `rst` asserted mid print_int of 987654321 with a byte pending → the next cycle shows IDLE and `out_valid`=0. A subsequent print_char with a0=0x5A emits only 0x5A.

Source files
------------

// File: rtl/syscall_pkg.sv
// syscall_unit shared types and constants.
// State enum, service codes, decimal power table and ASCII bytes.
package syscall_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGN,
    ST_SCAN,
    ST_EMIT,
    ST_CHAR,
    ST_DONE,
    ST_HALT
  } state_e;

  localparam logic [31:0] SVC_PRINT_INT_DEF  = 32'd1;
  localparam logic [31:0] SVC_EXIT_DEF       = 32'd10;
  localparam logic [31:0] SVC_PRINT_CHAR_DEF = 32'd11;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  localparam logic [0:9][31:0] POW10 = {
    32'd1,
    32'd10,
    32'd100,
    32'd1_000,
    32'd10_000,
    32'd100_000,
    32'd1_000_000,
    32'd10_000_000,
    32'd100_000_000,
    32'd1_000_000_000
  };

  function automatic logic [31:0] pow10(input logic [3:0] i);
    if (i > 4'd9) return 32'd0;
    return POW10[i];
  endfunction

endpackage

// File: rtl/dec_digit_gen.sv
// Decimal digit extraction by repeated subtraction of powers of ten.
// Drives the byte stream while the top FSM sits in EMIT.
module dec_digit_gen
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] mag_i,
  input  logic        scan_i,
  input  logic        emit_i,
  input  logic        out_ready_i,
  output logic        emit_now_o,
  output logic        last_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o
);

  logic [31:0] mag_q, mag_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  digit_q, digit_d;
  logic        started_q, started_d;
  logic [31:0] pow;
  logic        ge;

  assign pow = pow10(idx_q);
  assign ge  = mag_q >= pow;

  // Leading zeros are skipped, except the units digit.
  assign emit_now_o = scan_i & ~ge &
    ((digit_q != 4'd0) | started_q | (idx_q == 4'd0));

  assign last_o      = idx_q == 4'd0;
  assign out_valid_o = emit_i;
  assign out_data_o  = emit_i ? (ASCII_ZERO + {4'b0, digit_q}) : 8'h00;

  always_comb begin
    mag_d     = mag_q;
    idx_d     = idx_q;
    digit_d   = digit_q;
    started_d = started_q;
    if (load_i) begin
      mag_d     = mag_i;
      idx_d     = 4'd9;
      digit_d   = 4'd0;
      started_d = 1'b0;
    end else if (scan_i) begin
      if (ge) begin
        mag_d   = mag_q - pow;
        digit_d = digit_q + 4'd1;
      end else if (!emit_now_o) begin
        idx_d   = idx_q - 4'd1;
        digit_d = 4'd0;
      end
    end else if (emit_i) begin
      started_d = 1'b1;
      if (out_ready_i && idx_q != 4'd0) begin
        idx_d   = idx_q - 4'd1;
        digit_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q     <= 32'd0;
      idx_q     <= 4'd0;
      digit_q   <= 4'd0;
      started_q <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      idx_q     <= idx_d;
      digit_q   <= digit_d;
      started_q <= started_d;
    end
  end

endmodule

// File: rtl/syscall_unit.sv
// MIPS syscall service: print_int, print_char and exit.
// Stalls the core and streams ASCII bytes over valid/ready.
module syscall_unit
  import syscall_pkg::*;
#(
  parameter logic [31:0] SVC_PRINT_INT  = SVC_PRINT_INT_DEF,
  parameter logic [31:0] SVC_EXIT       = SVC_EXIT_DEF,
  parameter logic [31:0] SVC_PRINT_CHAR = SVC_PRINT_CHAR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        halted,
  output logic        unk_code
);

  state_e      state_q, state_d;
  logic [31:0] a0_q, a0_d;
  logic        unk_q, unk_d;

  logic        is_int, is_char, is_exit, known;
  logic        load;
  logic [31:0] mag_init;
  logic        in_scan, in_emit;
  logic        emit_now, last;
  logic        dg_valid;
  logic [7:0]  dg_data;

  assign is_int  = v0 == SVC_PRINT_INT;
  assign is_char = v0 == SVC_PRINT_CHAR;
  assign is_exit = v0 == SVC_EXIT;
  assign known   = is_int | is_char | is_exit;

  assign in_scan  = state_q == ST_SCAN;
  assign in_emit  = state_q == ST_EMIT;
  assign mag_init = a0_q[31] ? (32'd0 - a0_q) : a0_q;

  dec_digit_gen u_dg (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .mag_i       (mag_init),
    .scan_i      (in_scan),
    .emit_i      (in_emit),
    .out_ready_i (out_ready),
    .emit_now_o  (emit_now),
    .last_o      (last),
    .out_valid_o (dg_valid),
    .out_data_o  (dg_data)
  );

  always_comb begin
    state_d = state_q;
    a0_d    = a0_q;
    unk_d   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (syscall) begin
          a0_d = a0;
          if (is_int)       state_d = ST_SIGN;
          else if (is_char) state_d = ST_CHAR;
          else if (is_exit) state_d = ST_HALT;
          else              unk_d   = 1'b1;
        end
      end
      ST_SIGN: begin
        if (!a0_q[31] || out_ready) begin
          load    = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (emit_now) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) state_d = last ? ST_DONE : ST_SCAN;
      end
      ST_CHAR: begin
        if (out_ready) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_data = 8'h00;
    unique case (1'b1)
      state_q == ST_SIGN: out_data = a0_q[31] ? ASCII_MINUS : 8'h00;
      state_q == ST_CHAR: out_data = a0_q[7:0];
      in_emit:            out_data = dg_data;
      default:            out_data = 8'h00;
    endcase
  end

  assign out_valid = (state_q == ST_SIGN & a0_q[31]) |
                     dg_valid | (state_q == ST_CHAR);
  assign done      = state_q == ST_DONE;
  assign halted    = state_q == ST_HALT;
  assign unk_code  = unk_q;

  // Combinational IDLE term freezes the core in the acceptance cycle.
  assign stall = (syscall & (state_q == ST_IDLE) & known) |
                 (state_q == ST_SIGN) | in_scan | in_emit |
                 (state_q == ST_CHAR) | (state_q == ST_HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a0_q    <= 32'd0;
      unk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      unk_q   <= unk_d;
    end
  end

endmodule
